// File: rtl/load_store_buffer_pkg.sv
// Shared widths, opcode encodings and bus-match helper for the load/store buffer.
// Imported by the buffer top, the operand wakeup block and the bench.
package load_store_buffer_pkg;

    localparam int OP_ID_W      = 6;
    localparam int ROB_ID_W     = 5;
    localparam int DATA_W       = 32;
    localparam int IMM_W        = 32;
    localparam int LSB_SIZE_DEF = 16;

    localparam logic TRUE_B  = 1'b1;
    localparam logic FALSE_B = 1'b0;

    typedef enum logic [OP_ID_W-1:0] {
        OP_LB  = 6'd10,
        OP_LH  = 6'd11,
        OP_LW  = 6'd12,
        OP_LBU = 6'd13,
        OP_LHU = 6'd14,
        OP_SB  = 6'd15,
        OP_SH  = 6'd16,
        OP_SW  = 6'd17
    } op_id_e;

    function automatic logic bus_hit(
        input logic                valid,
        input logic [ROB_ID_W-1:0] bus_id,
        input logic [ROB_ID_W-1:0] tag
    );
        return valid && (bus_id == tag);
    endfunction

endpackage

// File: rtl/load_store_buffer_operand_wakeup.sv
// Resolves one pending operand against the CDB and LSU result buses.
// CDB wins when both buses match; both carry the same value for a given ROB id.
module lsb_operand_wakeup
    import load_store_buffer_pkg::*;
(
    input  logic                i_ready,
    input  logic [DATA_W-1:0]   i_value,
    input  logic [ROB_ID_W-1:0] i_tag,
    input  logic                i_cdb_valid,
    input  logic [ROB_ID_W-1:0] i_cdb_rob_id,
    input  logic [DATA_W-1:0]   i_cdb_value,
    input  logic                i_lsu_valid,
    input  logic [ROB_ID_W-1:0] i_lsu_rob_id,
    input  logic [DATA_W-1:0]   i_lsu_value,
    output logic                o_next_ready,
    output logic [DATA_W-1:0]   o_next_value
);

    // Select the broadcast value for a not-yet-ready operand whose tag matches.
    always_comb begin
        o_next_ready = i_ready;
        o_next_value = i_value;
        if (!i_ready) begin
            if (bus_hit(i_cdb_valid, i_cdb_rob_id, i_tag)) begin
                o_next_ready = TRUE_B;
                o_next_value = i_cdb_value;
            end else if (bus_hit(i_lsu_valid, i_lsu_rob_id, i_tag)) begin
                o_next_ready = TRUE_B;
                o_next_value = i_lsu_value;
            end else begin
                o_next_ready = i_ready;
            end
        end else begin
            o_next_value = i_value;
        end
    end

endmodule

// File: rtl/load_store_buffer.sv
// In-order load/store buffer: circular queue with result-bus wakeup, in-order
// issue of the head entry to the load/store ALU, and full flush on roll-back.
module load_store_buffer
    import load_store_buffer_pkg::*;
#(
    parameter int LSB_SIZE = LSB_SIZE_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                DP_valid,
    input  logic [OP_ID_W-1:0]  DP_OP_ID,
    input  logic [DATA_W-1:0]   DP_inst_pc,
    input  logic                DP_rs1_ready,
    input  logic                DP_rs2_ready,
    input  logic [DATA_W-1:0]   DP_rs1_value,
    input  logic [DATA_W-1:0]   DP_rs2_value,
    input  logic [ROB_ID_W-1:0] DP_rs1_tag,
    input  logic [ROB_ID_W-1:0] DP_rs2_tag,
    input  logic [IMM_W-1:0]    DP_imm,
    input  logic [ROB_ID_W-1:0] DP_ROB_id,
    output logic                DP_is_full,
    input  logic                ALU_enable,
    output logic                ALU_output_valid,
    output logic [OP_ID_W-1:0]  ALU_OP_ID,
    output logic [DATA_W-1:0]   ALU_inst_pc,
    output logic [DATA_W-1:0]   ALU_reg_rs1,
    output logic [DATA_W-1:0]   ALU_reg_rs2,
    output logic [IMM_W-1:0]    ALU_imm,
    output logic [ROB_ID_W-1:0] ALU_ROB_id,
    input  logic                CDB_valid,
    input  logic [ROB_ID_W-1:0] CDB_ROB_id,
    input  logic [DATA_W-1:0]   CDB_value,
    input  logic                LSU_valid,
    input  logic [ROB_ID_W-1:0] LSU_ROB_id,
    input  logic [DATA_W-1:0]   LSU_value,
    input  logic                ROB_roll_back_flag
);

    localparam int                IDX_W    = $clog2(LSB_SIZE);
    localparam logic [IDX_W-1:0]  PTR_ONE  = IDX_W'(1);
    localparam logic [IDX_W:0]    CNT_ONE  = (IDX_W+1)'(1);
    localparam logic [IDX_W:0]    CNT_FULL = (IDX_W+1)'(LSB_SIZE);

    logic                r_busy    [LSB_SIZE];
    logic [OP_ID_W-1:0]  r_op      [LSB_SIZE];
    logic [DATA_W-1:0]   r_pc      [LSB_SIZE];
    logic [IMM_W-1:0]    r_imm     [LSB_SIZE];
    logic [ROB_ID_W-1:0] r_rob     [LSB_SIZE];
    logic                r_rs1_rdy [LSB_SIZE];
    logic [DATA_W-1:0]   r_rs1_val [LSB_SIZE];
    logic [ROB_ID_W-1:0] r_rs1_tag [LSB_SIZE];
    logic                r_rs2_rdy [LSB_SIZE];
    logic [DATA_W-1:0]   r_rs2_val [LSB_SIZE];
    logic [ROB_ID_W-1:0] r_rs2_tag [LSB_SIZE];

    logic [IDX_W-1:0]    r_head;
    logic [IDX_W-1:0]    r_tail;
    logic [IDX_W:0]      r_count;

    logic                w_rs1_nrdy [LSB_SIZE];
    logic [DATA_W-1:0]   w_rs1_nval [LSB_SIZE];
    logic                w_rs2_nrdy [LSB_SIZE];
    logic [DATA_W-1:0]   w_rs2_nval [LSB_SIZE];

    logic                w_dp_rs1_rdy;
    logic [DATA_W-1:0]   w_dp_rs1_val;
    logic                w_dp_rs2_rdy;
    logic [DATA_W-1:0]   w_dp_rs2_val;

    logic                w_full;
    logic                w_dispatch;
    logic                w_issue;

    for (genvar g = 0; g < LSB_SIZE; g++) begin : g_wake
        lsb_operand_wakeup u_rs1 (
            .i_ready(r_rs1_rdy[g]), .i_value(r_rs1_val[g]), .i_tag(r_rs1_tag[g]),
            .i_cdb_valid(CDB_valid), .i_cdb_rob_id(CDB_ROB_id), .i_cdb_value(CDB_value),
            .i_lsu_valid(LSU_valid), .i_lsu_rob_id(LSU_ROB_id), .i_lsu_value(LSU_value),
            .o_next_ready(w_rs1_nrdy[g]), .o_next_value(w_rs1_nval[g])
        );
        lsb_operand_wakeup u_rs2 (
            .i_ready(r_rs2_rdy[g]), .i_value(r_rs2_val[g]), .i_tag(r_rs2_tag[g]),
            .i_cdb_valid(CDB_valid), .i_cdb_rob_id(CDB_ROB_id), .i_cdb_value(CDB_value),
            .i_lsu_valid(LSU_valid), .i_lsu_rob_id(LSU_ROB_id), .i_lsu_value(LSU_value),
            .o_next_ready(w_rs2_nrdy[g]), .o_next_value(w_rs2_nval[g])
        );
    end

    // Same-cycle bypass: an operand broadcast while it is being dispatched is stored ready.
    lsb_operand_wakeup u_dp_rs1 (
        .i_ready(DP_rs1_ready), .i_value(DP_rs1_value), .i_tag(DP_rs1_tag),
        .i_cdb_valid(CDB_valid), .i_cdb_rob_id(CDB_ROB_id), .i_cdb_value(CDB_value),
        .i_lsu_valid(LSU_valid), .i_lsu_rob_id(LSU_ROB_id), .i_lsu_value(LSU_value),
        .o_next_ready(w_dp_rs1_rdy), .o_next_value(w_dp_rs1_val)
    );
    lsb_operand_wakeup u_dp_rs2 (
        .i_ready(DP_rs2_ready), .i_value(DP_rs2_value), .i_tag(DP_rs2_tag),
        .i_cdb_valid(CDB_valid), .i_cdb_rob_id(CDB_ROB_id), .i_cdb_value(CDB_value),
        .i_lsu_valid(LSU_valid), .i_lsu_rob_id(LSU_ROB_id), .i_lsu_value(LSU_value),
        .o_next_ready(w_dp_rs2_rdy), .o_next_value(w_dp_rs2_val)
    );

    // Issue looks only at registered head state; no bus-to-issue path exists.
    always_comb begin
        w_full     = (r_count == CNT_FULL);
        w_dispatch = DP_valid && !w_full;
        w_issue    = ALU_enable && r_busy[r_head] && r_rs1_rdy[r_head] && r_rs2_rdy[r_head];
    end

    assign DP_is_full = w_full;

    // Queue state, wakeup, dispatch and issue; rst > !rdy > roll-back > normal.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LSB_SIZE; i++) begin
                r_busy[i] <= FALSE_B;
            end
            r_head           <= '0;
            r_tail           <= '0;
            r_count          <= '0;
            ALU_output_valid <= FALSE_B;
            ALU_OP_ID        <= '0;
            ALU_inst_pc      <= '0;
            ALU_reg_rs1      <= '0;
            ALU_reg_rs2      <= '0;
            ALU_imm          <= '0;
            ALU_ROB_id       <= '0;
        end else if (!rdy) begin
            ALU_output_valid <= ALU_output_valid;
        end else if (ROB_roll_back_flag) begin
            for (int i = 0; i < LSB_SIZE; i++) begin
                r_busy[i] <= FALSE_B;
            end
            r_head           <= '0;
            r_tail           <= '0;
            r_count          <= '0;
            ALU_output_valid <= FALSE_B;
        end else begin
            for (int i = 0; i < LSB_SIZE; i++) begin
                if (r_busy[i]) begin
                    r_rs1_rdy[i] <= w_rs1_nrdy[i];
                    r_rs1_val[i] <= w_rs1_nval[i];
                    r_rs2_rdy[i] <= w_rs2_nrdy[i];
                    r_rs2_val[i] <= w_rs2_nval[i];
                end
            end

            if (w_issue) begin
                ALU_output_valid <= TRUE_B;
                ALU_OP_ID        <= r_op[r_head];
                ALU_inst_pc      <= r_pc[r_head];
                ALU_reg_rs1      <= r_rs1_val[r_head];
                ALU_reg_rs2      <= r_rs2_val[r_head];
                ALU_imm          <= r_imm[r_head];
                ALU_ROB_id       <= r_rob[r_head];
                r_busy[r_head]   <= FALSE_B;
                r_head           <= r_head + PTR_ONE;
            end else begin
                ALU_output_valid <= FALSE_B;
            end

            // Head and tail only coincide when empty (no issue) or full (no dispatch).
            if (w_dispatch) begin
                r_busy[r_tail]    <= TRUE_B;
                r_op[r_tail]      <= DP_OP_ID;
                r_pc[r_tail]      <= DP_inst_pc;
                r_imm[r_tail]     <= DP_imm;
                r_rob[r_tail]     <= DP_ROB_id;
                r_rs1_rdy[r_tail] <= w_dp_rs1_rdy;
                r_rs1_val[r_tail] <= w_dp_rs1_val;
                r_rs1_tag[r_tail] <= DP_rs1_tag;
                r_rs2_rdy[r_tail] <= w_dp_rs2_rdy;
                r_rs2_val[r_tail] <= w_dp_rs2_val;
                r_rs2_tag[r_tail] <= DP_rs2_tag;
                r_tail            <= r_tail + PTR_ONE;
            end

            case ({w_dispatch, w_issue})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_buffer.sv
// Directed bench for load_store_buffer: a per-cycle vector table for the basic
// issue/wakeup/bypass cases plus hand sequences for fill/drain/wrap, roll-back and rdy hold.
module tb_load_store_buffer;
    import load_store_buffer_pkg::*;

    logic                clk = 1'b0;
    logic                rst, rdy;
    logic                DP_valid;
    logic [OP_ID_W-1:0]  DP_OP_ID;
    logic [DATA_W-1:0]   DP_inst_pc;
    logic                DP_rs1_ready, DP_rs2_ready;
    logic [DATA_W-1:0]   DP_rs1_value, DP_rs2_value;
    logic [ROB_ID_W-1:0] DP_rs1_tag, DP_rs2_tag;
    logic [IMM_W-1:0]    DP_imm;
    logic [ROB_ID_W-1:0] DP_ROB_id;
    logic                DP_is_full;
    logic                ALU_enable;
    logic                ALU_output_valid;
    logic [OP_ID_W-1:0]  ALU_OP_ID;
    logic [DATA_W-1:0]   ALU_inst_pc, ALU_reg_rs1, ALU_reg_rs2;
    logic [IMM_W-1:0]    ALU_imm;
    logic [ROB_ID_W-1:0] ALU_ROB_id;
    logic                CDB_valid, LSU_valid;
    logic [ROB_ID_W-1:0] CDB_ROB_id, LSU_ROB_id;
    logic [DATA_W-1:0]   CDB_value, LSU_value;
    logic                ROB_roll_back_flag;

    int n_checks = 0;
    int n_fail   = 0;

    load_store_buffer #(.LSB_SIZE(16)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .DP_valid(DP_valid), .DP_OP_ID(DP_OP_ID), .DP_inst_pc(DP_inst_pc),
        .DP_rs1_ready(DP_rs1_ready), .DP_rs2_ready(DP_rs2_ready),
        .DP_rs1_value(DP_rs1_value), .DP_rs2_value(DP_rs2_value),
        .DP_rs1_tag(DP_rs1_tag), .DP_rs2_tag(DP_rs2_tag),
        .DP_imm(DP_imm), .DP_ROB_id(DP_ROB_id), .DP_is_full(DP_is_full),
        .ALU_enable(ALU_enable), .ALU_output_valid(ALU_output_valid),
        .ALU_OP_ID(ALU_OP_ID), .ALU_inst_pc(ALU_inst_pc),
        .ALU_reg_rs1(ALU_reg_rs1), .ALU_reg_rs2(ALU_reg_rs2),
        .ALU_imm(ALU_imm), .ALU_ROB_id(ALU_ROB_id),
        .CDB_valid(CDB_valid), .CDB_ROB_id(CDB_ROB_id), .CDB_value(CDB_value),
        .LSU_valid(LSU_valid), .LSU_ROB_id(LSU_ROB_id), .LSU_value(LSU_value),
        .ROB_roll_back_flag(ROB_roll_back_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        dp_v;
        logic [5:0]  op;
        logic        r1_rdy;
        logic [31:0] r1;
        logic        r2_rdy;
        logic [31:0] r2;
        logic [31:0] imm;
        logic [4:0]  rob;
        logic        en;
        logic        cdb_v;
        logic [4:0]  cdb_id;
        logic [31:0] cdb_val;
        logic        lsu_v;
        logic [4:0]  lsu_id;
        logic [31:0] lsu_val;
        logic        e_vld;
        logic [5:0]  e_op;
        logic [31:0] e_r1;
        logic [31:0] e_r2;
        logic [31:0] e_imm;
        logic [4:0]  e_rob;
    } vec_t;

    vec_t tbl[$];
    vec_t last;

    // Operand fields carry the value when ready and the tag (low bits) when not.
    function automatic vec_t mk(input logic dv, input logic [5:0] op, input logic r1r,
                                input logic [31:0] r1, input logic r2r, input logic [31:0] r2,
                                input logic [31:0] imm, input logic [4:0] rob, input logic en);
        vec_t v;
        v = '{default: '0};
        v.dp_v = dv; v.op = op; v.r1_rdy = r1r; v.r1 = r1; v.r2_rdy = r2r; v.r2 = r2;
        v.imm = imm; v.rob = rob; v.en = en;
        return v;
    endfunction

    function automatic vec_t idle(input logic en);
        return mk(1'b0, 6'd0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 5'd0, en);
    endfunction

    function automatic vec_t iss(input vec_t v, input logic [5:0] op, input logic [31:0] r1,
                                 input logic [31:0] r2, input logic [31:0] imm, input logic [4:0] rob);
        vec_t o;
        o = v;
        o.e_vld = 1'b1; o.e_op = op; o.e_r1 = r1; o.e_r2 = r2; o.e_imm = imm; o.e_rob = rob;
        return o;
    endfunction

    function automatic vec_t cdb(input vec_t v, input logic [4:0] id, input logic [31:0] val);
        vec_t o;
        o = v; o.cdb_v = 1'b1; o.cdb_id = id; o.cdb_val = val;
        return o;
    endfunction

    function automatic vec_t lsu(input vec_t v, input logic [4:0] id, input logic [31:0] val);
        vec_t o;
        o = v; o.lsu_v = 1'b1; o.lsu_id = id; o.lsu_val = val;
        return o;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        DP_valid     = v.dp_v;
        DP_OP_ID     = v.op;
        DP_inst_pc   = 32'h100 + {25'd0, v.rob, 2'b00};
        DP_rs1_ready = v.r1_rdy; DP_rs1_value = v.r1; DP_rs1_tag = v.r1[4:0];
        DP_rs2_ready = v.r2_rdy; DP_rs2_value = v.r2; DP_rs2_tag = v.r2[4:0];
        DP_imm       = v.imm;
        DP_ROB_id    = v.rob;
        ALU_enable   = v.en;
        CDB_valid    = v.cdb_v; CDB_ROB_id = v.cdb_id; CDB_value = v.cdb_val;
        LSU_valid    = v.lsu_v; LSU_ROB_id = v.lsu_id; LSU_value = v.lsu_val;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Ready load/store with rs1 = base + i, rs2 = i, imm 0.
    task automatic dispatch_ready(input logic [4:0] rob, input logic [31:0] base, input logic en);
        drive(mk(1'b1, OP_SW, 1'b1, base + {27'd0, rob}, 1'b1, {27'd0, rob}, 32'd0, rob, en));
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; ROB_roll_back_flag = 1'b0;
        drive(idle(1'b0));
        last = idle(1'b0);
        step(); step();
        chk("reset valid", 32'(ALU_output_valid), 32'd0);
        chk("reset full", 32'(DP_is_full), 32'd0);
        chk("reset rs1", ALU_reg_rs1, 32'd0);
        chk("reset rob", 32'(ALU_ROB_id), 32'd0);
        chk("reset pc", ALU_inst_pc, 32'd0);
        rst = 1'b0;

        // Ready-at-dispatch load issues one cycle after dispatch.
        tbl.push_back(mk(1'b1, OP_LW, 1'b1, 32'h1000, 1'b1, 32'd0, 32'd4, 5'd3, 1'b1));
        tbl.push_back(iss(idle(1'b1), OP_LW, 32'h1000, 32'd0, 32'd4, 5'd3));
        tbl.push_back(idle(1'b0));
        // Store waiting on rs2 tag 5, woken by CDB two cycles later.
        tbl.push_back(mk(1'b1, OP_SW, 1'b1, 32'h2000, 1'b0, 32'd5, 32'd8, 5'd4, 1'b1));
        tbl.push_back(idle(1'b1));
        tbl.push_back(cdb(idle(1'b1), 5'd5, 32'hDEADBEEF));
        tbl.push_back(iss(idle(1'b1), OP_SW, 32'h2000, 32'hDEADBEEF, 32'd8, 5'd4));
        tbl.push_back(idle(1'b0));
        // Blocked head (tag 7) holds back a ready younger entry until LSU wakes it.
        tbl.push_back(mk(1'b1, OP_LB, 1'b0, 32'd7, 1'b1, 32'd0, 32'd0, 5'd6, 1'b1));
        tbl.push_back(cdb(mk(1'b1, OP_LH, 1'b1, 32'h30, 1'b1, 32'h31, 32'd2, 5'd8, 1'b1), 5'd6, 32'h66));
        tbl.push_back(idle(1'b1));
        tbl.push_back(lsu(idle(1'b1), 5'd7, 32'h7777));
        tbl.push_back(iss(idle(1'b1), OP_LB, 32'h7777, 32'd0, 32'd0, 5'd6));
        tbl.push_back(idle(1'b0));
        tbl.push_back(iss(idle(1'b1), OP_LH, 32'h30, 32'h31, 32'd2, 5'd8));
        tbl.push_back(idle(1'b0));
        // Same-cycle CDB bypass of rs1 at dispatch.
        tbl.push_back(cdb(mk(1'b1, OP_LBU, 1'b0, 32'd2, 1'b1, 32'h11, 32'd0, 5'd9, 1'b1), 5'd2, 32'h55));
        tbl.push_back(iss(idle(1'b1), OP_LBU, 32'h55, 32'h11, 32'd0, 5'd9));
        tbl.push_back(idle(1'b0));

        for (int r = 0; r < tbl.size(); r++) begin
            drive(tbl[r]);
            step();
            chk($sformatf("row%0d valid", r), 32'(ALU_output_valid), 32'(tbl[r].e_vld));
            chk($sformatf("row%0d full", r), 32'(DP_is_full), 32'd0);
            if (tbl[r].e_vld) begin
                chk($sformatf("row%0d op", r), 32'(ALU_OP_ID), 32'(tbl[r].e_op));
                chk($sformatf("row%0d rs1", r), ALU_reg_rs1, tbl[r].e_r1);
                chk($sformatf("row%0d rs2", r), ALU_reg_rs2, tbl[r].e_r2);
                chk($sformatf("row%0d imm", r), ALU_imm, tbl[r].e_imm);
                chk($sformatf("row%0d rob", r), 32'(ALU_ROB_id), 32'(tbl[r].e_rob));
                chk($sformatf("row%0d pc", r), ALU_inst_pc, 32'h100 + {25'd0, tbl[r].e_rob, 2'b00});
                last = tbl[r];
            end else begin
                chk($sformatf("row%0d hold rs1", r), ALU_reg_rs1, last.e_r1);
                chk($sformatf("row%0d hold rob", r), 32'(ALU_ROB_id), 32'(last.e_rob));
            end
        end

        // Fill 16 with ALU stalled; pointers start mid-queue so tail wraps.
        for (int i = 0; i < 16; i++) begin
            dispatch_ready(5'(i), 32'h1000, 1'b0);
            step();
            chk($sformatf("fill%0d full", i), 32'(DP_is_full), (i == 15) ? 32'd1 : 32'd0);
            chk($sformatf("fill%0d valid", i), 32'(ALU_output_valid), 32'd0);
        end
        dispatch_ready(5'd20, 32'h1000, 1'b0);
        step();
        chk("17th full", 32'(DP_is_full), 32'd1);
        drive(idle(1'b1));
        for (int i = 0; i < 16; i++) begin
            step();
            chk($sformatf("drain%0d valid", i), 32'(ALU_output_valid), 32'd1);
            chk($sformatf("drain%0d rob", i), 32'(ALU_ROB_id), 32'(i));
            chk($sformatf("drain%0d rs1", i), ALU_reg_rs1, 32'h1000 + 32'(i));
            chk($sformatf("drain%0d full", i), 32'(DP_is_full), 32'd0);
        end
        step();
        chk("dropped 17th", 32'(ALU_output_valid), 32'd0);

        // Three more through the wrapped pointers, streaming.
        for (int k = 0; k < 3; k++) begin
            dispatch_ready(5'(21 + k), 32'h3000, 1'b1);
            step();
            chk($sformatf("wrap%0d valid", k), 32'(ALU_output_valid), (k == 0) ? 32'd0 : 32'd1);
            if (k > 0) chk($sformatf("wrap%0d rob", k), 32'(ALU_ROB_id), 32'(21 + k - 1));
        end
        drive(idle(1'b1));
        step();
        chk("wrap last rob", 32'(ALU_ROB_id), 32'd23);
        chk("wrap last rs1", ALU_reg_rs1, 32'h3000 + 32'd23);
        step();
        chk("wrap empty", 32'(ALU_output_valid), 32'd0);

        // Roll-back with a simultaneous dispatch flushes everything.
        for (int i = 0; i < 5; i++) begin
            dispatch_ready(5'(24 + i), 32'h4000, 1'b0);
            step();
        end
        dispatch_ready(5'd30, 32'h4000, 1'b1);
        ROB_roll_back_flag = 1'b1;
        step();
        ROB_roll_back_flag = 1'b0;
        chk("rb full", 32'(DP_is_full), 32'd0);
        chk("rb valid", 32'(ALU_output_valid), 32'd0);
        drive(idle(1'b1));
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("rb idle%0d", i), 32'(ALU_output_valid), 32'd0);
        end
        dispatch_ready(5'd12, 32'h5000, 1'b1);
        step();
        chk("post-rb wait", 32'(ALU_output_valid), 32'd0);
        drive(idle(1'b1));
        step();
        chk("post-rb valid", 32'(ALU_output_valid), 32'd1);
        chk("post-rb rob", 32'(ALU_ROB_id), 32'd12);

        // rdy low holds the issue pulse and ignores dispatch.
        dispatch_ready(5'd13, 32'h6000, 1'b1);
        step();
        drive(idle(1'b1));
        step();
        chk("rdy pre valid", 32'(ALU_output_valid), 32'd1);
        chk("rdy pre rob", 32'(ALU_ROB_id), 32'd13);
        rdy = 1'b0;
        dispatch_ready(5'd14, 32'h6000, 1'b1);
        step();
        chk("rdy hold valid", 32'(ALU_output_valid), 32'd1);
        step();
        chk("rdy hold valid2", 32'(ALU_output_valid), 32'd1);
        rdy = 1'b1;
        drive(idle(1'b1));
        step();
        chk("rdy drop dispatch", 32'(ALU_output_valid), 32'd0);
        step();
        chk("rdy no late issue", 32'(ALU_output_valid), 32'd0);
        chk("rdy rob held", 32'(ALU_ROB_id), 32'd13);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
